// File: rtl/debouncer_bank.sv
// N-channel switch/button debouncer: one shared prescaler tick, per-channel 2-FF
// synchroniser, stability counter, clean level, press/release pulses and long-press hold pulse.
module debouncer_bank #(
    parameter int                  CHANNELS     = 4,
    parameter int                  TICK_DIV     = 50000,
    parameter int                  STABLE_TICKS = 20,
    parameter int                  HOLD_TICKS   = 1000,
    parameter logic [CHANNELS-1:0] INVERT       = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [CHANNELS-1:0] noisy,
    output logic [CHANNELS-1:0] clean,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold,
    output logic                tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);

    logic [PW-1:0]       r_pre_cnt;
    logic                r_tick;
    logic                w_step;
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;

    // Prescaler and tick both freeze while en=0, so a pause shifts every
    // later tick by exactly the paused cycles instead of dropping one.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (en) begin
            if (r_pre_cnt == PRE_LAST) begin
                r_pre_cnt <= '0;
                r_tick    <= 1'b1;
            end else begin
                r_pre_cnt <= r_pre_cnt + PW'(1);
                r_tick    <= 1'b0;
            end
        end
    end

    assign w_step = r_tick & en;
    assign tick   = w_step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= noisy ^ INVERT;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
        logic [SW-1:0] r_stab_cnt;
        logic          r_clean_ch;
        logic          r_rise_ch;
        logic          r_fall_ch;

        // Any sample agreeing with clean restarts the count: this is the glitch reject.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_stab_cnt <= '0;
                r_clean_ch <= 1'b0;
                r_rise_ch  <= 1'b0;
                r_fall_ch  <= 1'b0;
            end else begin
                r_rise_ch <= 1'b0;
                r_fall_ch <= 1'b0;
                if (r_sync2[i] == r_clean_ch) begin
                    r_stab_cnt <= '0;
                end else if (w_step) begin
                    if (r_stab_cnt == STAB_LAST) begin
                        r_stab_cnt <= '0;
                        r_clean_ch <= r_sync2[i];
                        r_rise_ch  <= r_sync2[i];
                        r_fall_ch  <= ~r_sync2[i];
                    end else begin
                        r_stab_cnt <= r_stab_cnt + SW'(1);
                    end
                end
            end
        end

        assign clean[i] = r_clean_ch;
        assign rise[i]  = r_rise_ch;
        assign fall[i]  = r_fall_ch;

        if (HOLD_TICKS > 0) begin : gen_hold
            localparam int HW = $clog2(HOLD_TICKS + 1);
            localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
            localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_TICKS - 1);

            logic [HW-1:0] r_hold_cnt;
            logic          r_hold_ch;

            // Saturating at HOLD_MAX gives one pulse per press; release re-arms it.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_hold_cnt <= '0;
                    r_hold_ch  <= 1'b0;
                end else begin
                    r_hold_ch <= 1'b0;
                    if (!r_clean_ch) begin
                        r_hold_cnt <= '0;
                    end else if (w_step && (r_hold_cnt != HOLD_MAX)) begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                        r_hold_ch  <= (r_hold_cnt == HOLD_PRE);
                    end
                end
            end

            assign hold[i] = r_hold_ch;
        end else begin : gen_no_hold
            assign hold[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed bench for debouncer_bank: three instances cover timing/bounce/reset,
// prescaler/enable, and hold/inversion/multi-channel behaviour.
module tb_debouncer_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: 2 channels, tick every cycle, STABLE_TICKS=4, no hold.
    logic       rst_a = 1'b0, en_a = 1'b1, tick_a;
    logic [1:0] noisy_a = 2'b00, clean_a, rise_a, fall_a, hold_a;
    // Instance B: 1 channel, TICK_DIV=3, STABLE_TICKS=2.
    logic       rst_b = 1'b0, en_b = 1'b1, tick_b;
    logic [0:0] noisy_b = 1'b0, clean_b, rise_b, fall_b, hold_b;
    // Instance C: 4 channels, tick every cycle, STABLE_TICKS=2, HOLD_TICKS=8, channel 1 inverted.
    logic       rst_c = 1'b0, en_c = 1'b1, tick_c;
    logic [3:0] noisy_c = 4'b1111, clean_c, rise_c, fall_c, hold_c;

    debouncer_bank #(.CHANNELS(2), .TICK_DIV(1), .STABLE_TICKS(4), .HOLD_TICKS(0), .INVERT(2'b00)) u_a (
        .clk(clk), .reset(rst_a), .en(en_a), .noisy(noisy_a),
        .clean(clean_a), .rise(rise_a), .fall(fall_a), .hold(hold_a), .tick(tick_a));

    debouncer_bank #(.CHANNELS(1), .TICK_DIV(3), .STABLE_TICKS(2), .HOLD_TICKS(0), .INVERT(1'b0)) u_b (
        .clk(clk), .reset(rst_b), .en(en_b), .noisy(noisy_b),
        .clean(clean_b), .rise(rise_b), .fall(fall_b), .hold(hold_b), .tick(tick_b));

    debouncer_bank #(.CHANNELS(4), .TICK_DIV(1), .STABLE_TICKS(2), .HOLD_TICKS(8), .INVERT(4'b0010)) u_c (
        .clk(clk), .reset(rst_c), .en(en_c), .noisy(noisy_c),
        .clean(clean_c), .rise(rise_c), .fall(fall_c), .hold(hold_c), .tick(tick_c));

    typedef struct {
        logic [1:0] noisy;
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
    } vec_t;

    vec_t vecs [29];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] e_clean, e_rise, e_fall, e_hold;
        bit found;

        // Timing (rows 0-6), release (7-13), bounce then stable press (14-28).
        vecs = '{
            '{2'b01, 2'b00, 2'b00, 2'b00}, '{2'b01, 2'b00, 2'b00, 2'b00},
            '{2'b01, 2'b00, 2'b00, 2'b00}, '{2'b01, 2'b00, 2'b00, 2'b00},
            '{2'b01, 2'b00, 2'b00, 2'b00}, '{2'b01, 2'b01, 2'b01, 2'b00},
            '{2'b01, 2'b01, 2'b00, 2'b00},
            '{2'b00, 2'b01, 2'b00, 2'b00}, '{2'b00, 2'b01, 2'b00, 2'b00},
            '{2'b00, 2'b01, 2'b00, 2'b00}, '{2'b00, 2'b01, 2'b00, 2'b00},
            '{2'b00, 2'b01, 2'b00, 2'b00}, '{2'b00, 2'b00, 2'b00, 2'b01},
            '{2'b00, 2'b00, 2'b00, 2'b00},
            '{2'b01, 2'b00, 2'b00, 2'b00}, '{2'b01, 2'b00, 2'b00, 2'b00},
            '{2'b00, 2'b00, 2'b00, 2'b00}, '{2'b00, 2'b00, 2'b00, 2'b00},
            '{2'b01, 2'b00, 2'b00, 2'b00}, '{2'b01, 2'b00, 2'b00, 2'b00},
            '{2'b00, 2'b00, 2'b00, 2'b00}, '{2'b00, 2'b00, 2'b00, 2'b00},
            '{2'b01, 2'b00, 2'b00, 2'b00}, '{2'b01, 2'b00, 2'b00, 2'b00},
            '{2'b01, 2'b00, 2'b00, 2'b00}, '{2'b01, 2'b00, 2'b00, 2'b00},
            '{2'b01, 2'b00, 2'b00, 2'b00}, '{2'b01, 2'b01, 2'b01, 2'b00},
            '{2'b01, 2'b01, 2'b00, 2'b00}
        };

        // Reset state with noisy inputs already high on instance C.
        repeat (3) step();
        check("reset clean_a", 32'(clean_a), 0);
        check("reset rise_a", 32'(rise_a), 0);
        check("reset tick_a", 32'(tick_a), 0);
        check("reset clean_b", 32'(clean_b), 0);
        check("reset tick_b", 32'(tick_b), 0);
        check("reset clean_c", 32'(clean_c), 0);
        check("reset hold_c", 32'(hold_c), 0);
        check("reset fall_c", 32'(fall_c), 0);

        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (10) step();
        check("idle clean_a", 32'(clean_a), 0);
        check("no-hold hold_a", 32'(hold_a), 0);
        check("no-hold hold_b", 32'(hold_b), 0);

        // Table-driven vectors on instance A.
        for (int j = 0; j < 29; j++) begin
            noisy_a = vecs[j].noisy;
            step();
            check($sformatf("vec%0d clean", j), 32'(clean_a), 32'(vecs[j].clean));
            check($sformatf("vec%0d rise", j), 32'(rise_a), 32'(vecs[j].rise));
            check($sformatf("vec%0d fall", j), 32'(fall_a), 32'(vecs[j].fall));
            check($sformatf("vec%0d tick", j), 32'(tick_a), 1);
        end

        // Reset mid-debounce: channel 0 at count 3 of 4 towards 0, channel 1 high.
        noisy_a = 2'b11;
        repeat (8) step();
        check("pre-reset clean_a", 32'(clean_a), 32'h3);
        noisy_a = 2'b10;
        for (int j = 0; j < 5; j++) begin
            step();
            check($sformatf("mid-debounce row%0d clean", j), 32'(clean_a), 32'h3);
            check($sformatf("mid-debounce row%0d fall", j), 32'(fall_a), 0);
        end
        rst_a = 1'b0;
        #1;
        check("async reset clean_a", 32'(clean_a), 0);
        check("async reset rise_a", 32'(rise_a), 0);
        check("async reset fall_a", 32'(fall_a), 0);
        check("async reset tick_a", 32'(tick_a), 0);
        step();
        rst_a = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            check($sformatf("post-reset row%0d clean", j), 32'(clean_a), (j >= 5) ? 32'h2 : 32'h0);
            check($sformatf("post-reset row%0d rise", j), 32'(rise_a), (j == 5) ? 32'h2 : 32'h0);
            check($sformatf("post-reset row%0d fall", j), 32'(fall_a), 0);
        end

        // Prescaler on instance B: find a tick, then check period 3.
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            if (tick_b) found = 1'b1;
        end
        check("tick_b seen within budget", 32'(found), 1);
        for (int j = 1; j <= 6; j++) begin
            step();
            check($sformatf("tick_b period row%0d", j), 32'(tick_b), (j % 3 == 0) ? 1 : 0);
        end
        // Press: second tick after s differs updates clean.
        noisy_b = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            step();
            check($sformatf("presc press row%0d clean", j), 32'(clean_b), (j >= 7) ? 1 : 0);
            check($sformatf("presc press row%0d rise", j), 32'(rise_b), (j == 7) ? 1 : 0);
        end
        step();
        check("presc tick realign", 32'(tick_b), 1);
        // Release with en=0 for 10 cycles after the first counted tick.
        noisy_b = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            if (j == 5) en_b = 1'b0;
            if (j == 15) en_b = 1'b1;
            step();
            check($sformatf("pause row%0d clean", j), 32'(clean_b), (j >= 17) ? 0 : 1);
            check($sformatf("pause row%0d fall", j), 32'(fall_b), (j == 17) ? 1 : 0);
            if (j >= 5 && j < 15) check($sformatf("pause row%0d tick", j), 32'(tick_b), 0);
        end
        check("resume tick_b", 32'(tick_b), 0);

        // Instance C: inversion, multi-channel, hold and re-arm.
        rst_c = 1'b1;
        for (int j = 0; j <= 45; j++) begin
            if (j < 21)      noisy_c = 4'b1111;
            else if (j < 26) noisy_c = 4'b1101;
            else if (j < 31) noisy_c = 4'b1100;
            else             noisy_c = 4'b1101;
            step();
            e_clean = 4'b0000;
            e_rise  = 4'b0000;
            e_fall  = 4'b0000;
            e_hold  = 4'b0000;
            if (j >= 3) begin
                e_clean[3:2] = 2'b11;
                e_clean[0]   = !(j >= 29 && j < 34);
                e_clean[1]   = (j >= 24);
            end
            if (j == 3)  e_rise = 4'b1101;
            if (j == 34) e_rise[0] = 1'b1;
            if (j == 24) e_rise[1] = 1'b1;
            if (j == 29) e_fall[0] = 1'b1;
            if (j == 11) e_hold = 4'b1101;
            if (j == 32) e_hold[1] = 1'b1;
            if (j == 42) e_hold[0] = 1'b1;
            check($sformatf("chan row%0d clean", j), 32'(clean_c), 32'(e_clean));
            check($sformatf("chan row%0d rise", j), 32'(rise_c), 32'(e_rise));
            check($sformatf("chan row%0d fall", j), 32'(fall_c), 32'(e_fall));
            check($sformatf("chan row%0d hold", j), 32'(hold_c), 32'(e_hold));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/debouncer_bank.md
Name: debouncer_bank

Overview:
- Parametrised N-channel debouncer for switches and buttons, with edge pulses and long-press detection.
- Sits between raw board inputs and control FSMs.
- One shared prescaler generates a timebase tick, so the per-channel counters stay narrow.
- Each channel has its own synchroniser, stability counter, clean level, press/release pulses and a hold pulse.

Parameters:
- CHANNELS, 4: number of independent input channels (1..32).
- TICK_DIV, 50000: clock cycles per timebase tick (≥1; 1 = tick every cycle).
- STABLE_TICKS, 20: consecutive ticks the synchronised input must differ from clean before clean changes (≥1).
- HOLD_TICKS, 1000: ticks clean must stay 1 before a hold pulse fires (0 = hold disabled).
- INVERT, 0: CHANNELS-bit mask; bit i=1 inverts noisy[i] before the synchroniser (active-low buttons).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  1 = prescaler and counters run; 0 = freeze prescaler and all counters (synchronisers keep running).
- noisy  in  CHANNELS  raw asynchronous inputs.
- clean  out  CHANNELS  debounced level per channel.
- rise  out  CHANNELS  1-cycle pulse when clean goes 0→1.
- fall  out  CHANNELS  1-cycle pulse when clean goes 1→0.
- hold  out  CHANNELS  1-cycle pulse when clean has been 1 for HOLD_TICKS ticks.
- tick  out  1  timebase strobe, for observability.

Behaviour:
- Reset (reset=0, async): synchronisers, prescaler, all counters, clean, rise, fall, hold and tick = 0.
- Synchroniser per channel: 2-FF chain on noisy[i]^INVERT[i]; s[i] = second stage.
- Prescaler:
  - counts 0..TICK_DIV-1 while en=1, then wraps to 0.
  - tick is registered and is 1 for exactly one cycle when the counter wraps, giving period TICK_DIV.
  - TICK_DIV=1 → tick constant 1 while en=1.
  - en=0 → counter holds and tick=0.
- Stability counter per channel, width $clog2(STABLE_TICKS+1):
  - s==clean → counter cleared to 0 every cycle, independent of tick and en. This is the glitch reject.
  - s!=clean and tick → counter increments.
  - s!=clean, tick, and counter==STABLE_TICKS-1 → clean<=s and counter<=0 on the same edge.
- Latency: with TICK_DIV=1 and a level change first sampled at edge k, clean changes at edge k+1+STABLE_TICKS.
- Edge pulses: registered, asserted in the same cycle clean first shows its new value, deasserted the next cycle. rise and fall are never both 1 on one channel.
- Hold counter per channel, width $clog2(HOLD_TICKS+1):
  - clean==0 → cleared.
  - clean==1 and tick → increments, saturating at HOLD_TICKS.
  - hold pulses for one cycle on the edge where the counter becomes HOLD_TICKS. At most one hold per press.
  - Release, then a new press, re-arms it.
  - HOLD_TICKS=0 → hold tied 0 and the counter is removed.
- Channels are fully independent: simultaneous changes on several channels produce simultaneous, independent pulses.
- en=0 mid-debounce: counters freeze (they are not cleared), apart from the s==clean clear rule. Resuming continues from the frozen count.
- Reset asserted mid-operation clears everything immediately. After release, clean=0 even if an input is held high; that channel then debounces to 1 after the normal latency.
- Counters never wrap: stability is bounded by STABLE_TICKS-1, hold saturates.

Test Plan:
1. Timing, STABLE_TICKS=4: TICK_DIV=1, CHANNELS=2, noisy[0] 0→1 first sampled at edge k → clean[0]=1 and rise[0]=1 at edge k+5 only; rise[0]=0 at k+6; clean[1] stays 0.
2. Bounce rejection, STABLE_TICKS=4: TICK_DIV=1, noisy[0] toggles 1,0,1,0 each for 2 cycles, then holds 1 → no rise during the bounce; clean[0]=1 exactly 5 edges after the final stable sample.
3. Prescaler: TICK_DIV=3, STABLE_TICKS=2 → tick period 3 cycles. Clean changes on the second tick after s differs. en=0 for 10 cycles mid-count delays clean by exactly 10 cycles.
4. Hold: TICK_DIV=1, STABLE_TICKS=2, HOLD_TICKS=8, input held high 30 cycles → exactly one hold pulse, 8 cycles after rise. Release then re-press → fall, rise, then a second hold.
5. Inversion and multi-channel: INVERT=4'b0010; noisy=4'b1111 at reset release → channels 0, 2, 3 raise clean and rise together; channel 1 stays 0. Then noisy[1]=0 → rise[1] only.
6. Reset mid-debounce: reset pulsed low for 1 cycle with counter at 3 of 4 → all outputs 0 immediately. After release, the full latency applies again and no spurious fall occurs.
